sseg_scan_decoder: RTL and testbench

- Passive monitor on the multiplexed seven-segment bus (an/sseg) that the display drivers produce, e.g. on reaction_timer.
- Follows the anode scan, samples each digit's segment pattern once it is stable, and converts it back to a 4-bit value.
- Publishes one complete display frame at a time.
- Used in self-checking benches and on-chip self-test to read back what the display shows.

---
 rtl/sseg_scan_decoder.sv | 178 +++++++++++++++++
 tb/tb_sseg_scan_decoder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_decoder.sv
// sseg_scan_decoder
//   Passive monitor for a multiplexed seven-segment display bus. It follows
//   the active-low anode scan and waits until each digit's an/sseg pair has
//   been stable for STABLE_CYC samples. It then decodes the segment pattern
//   back into a 4-bit value and publishes a complete frame once every digit
//   has been seen.
//
//   Optional feature: define SSEG_DEC_HEX_EN to also accept the A,b,C,d,E,F
//   glyphs (4'hA..4'hF). Without it those glyphs are illegal patterns.
//
// Parameters
//   NUM_DIG    number of scanned digits (1..8)
//   STABLE_CYC consecutive identical samples before a digit is captured (>=1)
//   TIMEOUT    cycles without a published frame before valid drops (>=2)
//
// Ports
//   clk        system clock
//   clear      synchronous active-high reset
//   an         anode enables, active-low (an[7:NUM_DIG] must stay high)
//   sseg       segments, active-low, {dp,g,f,e,d,c,b,a}
//   digits     decoded values, digit i at [4i+3:4i]
//   dp         decimal point per digit, 1 = lit
//   blank      1 = digit showed no segments
//   valid      a frame was published and no timeout has occurred since
//   frame_done one-cycle pulse when digits/dp/blank update
//   err        sticky illegal-pattern / illegal-anode flag
module sseg_scan_decoder #(
    parameter int NUM_DIG    = 4,
    parameter int STABLE_CYC = 4,
    parameter int TIMEOUT    = 1000000
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic [7:0]           an,
    input  logic [7:0]           sseg,
    output logic [4*NUM_DIG-1:0] digits,
    output logic [NUM_DIG-1:0]   dp,
    output logic [NUM_DIG-1:0]   blank,
    output logic                 valid,
    output logic                 frame_done,
    output logic                 err
);

    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYC);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);
    localparam logic [TW-1:0] TO_PRE   = TW'(TIMEOUT - 1);
    // Anodes above the scanned range; these must read back high.
    localparam logic [7:0]    HI_AN    = 8'hFF << NUM_DIG;

    // Returns {bad, blank, value} for an active-low gfedcba pattern.
    function automatic logic [5:0] seg_decode(input logic [6:0] s);
        logic [5:0] r;
        case (s)
            7'b1000000: r = {2'b00, 4'h0};
            7'b1111001: r = {2'b00, 4'h1};
            7'b0100100: r = {2'b00, 4'h2};
            7'b0110000: r = {2'b00, 4'h3};
            7'b0011001: r = {2'b00, 4'h4};
            7'b0010010: r = {2'b00, 4'h5};
            7'b0000010: r = {2'b00, 4'h6};
            7'b1111000: r = {2'b00, 4'h7};
            7'b0000000: r = {2'b00, 4'h8};
            7'b0010000: r = {2'b00, 4'h9};
            7'b1111111: r = {2'b01, 4'h0};
`ifdef SSEG_DEC_HEX_EN
            7'b0001000: r = {2'b00, 4'hA};
            7'b0000011: r = {2'b00, 4'hB};
            7'b1000110: r = {2'b00, 4'hC};
            7'b0100001: r = {2'b00, 4'hD};
            7'b0000110: r = {2'b00, 4'hE};
            7'b0001110: r = {2'b00, 4'hF};
`endif
            default:    r = {2'b10, 4'h0};
        endcase
        return r;
    endfunction

    logic [15:0]          prev_q;
    logic [SW-1:0]        stab_q, stab_d;
    logic [NUM_DIG-1:0]   mask_q, mask_d;
    logic [TW-1:0]        to_q, to_d;
    logic                 err_d;

    logic [4*NUM_DIG-1:0] shad_dig_q;
    logic [NUM_DIG-1:0]   shad_dp_q;
    logic [NUM_DIG-1:0]   shad_blank_q;

    logic [NUM_DIG-1:0]   sel;
    logic                 an_legal, an_idle, same, capture, publish, timeout_hit;
    logic [5:0]           dec;

    assign sel      = ~an[NUM_DIG-1:0];
    assign an_legal = ((an & HI_AN) == HI_AN) && $onehot(sel);
    assign an_idle  = (an == 8'hFF);
    assign dec      = seg_decode(sseg[6:0]);

    always_comb begin
        same = ({an, sseg} == prev_q);
        if (!same) begin
            stab_d = SW'(1);
        end else if (stab_q == STAB_MAX) begin
            stab_d = stab_q;
        end else begin
            stab_d = stab_q + 1'b1;
        end

        // Capture only on the transition into the saturated count, so a
        // digit held for a long time is captured exactly once. The !same
        // term covers STABLE_CYC == 1, where every change is a new activation.
        capture = an_legal && (stab_d == STAB_MAX) && (!same || stab_q != STAB_MAX);

        publish     = &mask_q;
        // Fires once on the transition into saturation; publish has priority.
        timeout_hit = !publish && (to_q == TO_PRE);

        mask_d = (publish || timeout_hit) ? '0 : mask_q;
        if (capture) begin
            mask_d = mask_d | sel;
        end

        if (publish) begin
            to_d = '0;
        end else if (to_q == TO_MAX) begin
            to_d = to_q;
        end else begin
            to_d = to_q + 1'b1;
        end

        err_d = err | (!an_legal && !an_idle) | (capture && dec[5]);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            prev_q     <= '0;
            stab_q     <= '0;
            mask_q     <= '0;
            to_q       <= '0;
            digits     <= '0;
            dp         <= '0;
            blank      <= '0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            prev_q     <= {an, sseg};
            stab_q     <= stab_d;
            mask_q     <= mask_d;
            to_q       <= to_d;
            frame_done <= publish;
            err        <= err_d;
            if (publish) begin
                digits <= shad_dig_q;
                dp     <= shad_dp_q;
                blank  <= shad_blank_q;
                valid  <= 1'b1;
            end else if (timeout_hit) begin
                valid  <= 1'b0;
            end
        end
    end

    // Shadows are only published once the mask proves every digit was
    // written after the last clear, so they need no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < NUM_DIG; i++) begin
                if (sel[i]) begin
                    shad_dig_q[4*i +: 4] <= dec[3:0];
                    shad_dp_q[i]         <= ~sseg[7];
                    shad_blank_q[i]      <= dec[4];
                end
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Testbench for sseg_scan_decoder (NUM_DIG=4, STABLE_CYC=2, TIMEOUT=50).
// A behavioural model tracks run lengths of identical samples, the set of
// digits seen in the current frame and the cycles since the last frame; it
// is compared against the DUT after every clock edge. Directed literal checks
// pin the expected frame contents at key points.
module tb_sseg_scan_decoder;

    localparam int NUM_DIG    = 4;
    localparam int STABLE_CYC = 2;
    localparam int TIMEOUT    = 50;

    logic        clk   = 1'b0;
    logic        clear = 1'b1;
    logic [7:0]  an    = 8'hFF;
    logic [7:0]  sseg  = 8'hFF;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        valid;
    logic        frame_done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sseg_scan_decoder #(
        .NUM_DIG   (NUM_DIG),
        .STABLE_CYC(STABLE_CYC),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .clear     (clear),
        .an        (an),
        .sseg      (sseg),
        .digits    (digits),
        .dp        (dp),
        .blank     (blank),
        .valid     (valid),
        .frame_done(frame_done),
        .err       (err)
    );

    // ---------------- behavioural model ----------------
    logic [6:0]  pat [16];
    int          n_pat;
    logic [15:0] m_digits;
    logic [3:0]  m_dp, m_blank;
    bit          m_valid, m_fd, m_err;
    bit          m_mask [4];
    logic [3:0]  sh_val [4];
    bit          sh_dp [4];
    bit          sh_blank [4];
    int          run, last, since;

    initial begin
        pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100;
        pat[3] = 7'b0110000; pat[4] = 7'b0011001; pat[5] = 7'b0010010;
        pat[6] = 7'b0000010; pat[7] = 7'b1111000; pat[8] = 7'b0000000;
        pat[9] = 7'b0010000;
        pat[10] = 7'b0001000; pat[11] = 7'b0000011; pat[12] = 7'b1000110;
        pat[13] = 7'b0100001; pat[14] = 7'b0000110; pat[15] = 7'b0001110;
`ifdef SSEG_DEC_HEX_EN
        n_pat = 16;
`else
        n_pat = 10;
`endif
    end

    task automatic model_edge(input logic c, input logic [7:0] a, input logic [7:0] s);
        int  samp, zeros, idx, val;
        bit  full, legal, found;
        if (c) begin
            m_digits = '0; m_dp = '0; m_blank = '0;
            m_valid = 0; m_fd = 0; m_err = 0;
            for (int i = 0; i < 4; i++) m_mask[i] = 0;
            run = 0; last = -1; since = 0;
            return;
        end
        samp = int'({a, s});
        run  = (samp == last) ? run + 1 : 1;
        last = samp;

        full = 1;
        for (int i = 0; i < 4; i++) if (!m_mask[i]) full = 0;
        m_fd = 0;
        if (full) begin
            for (int i = 0; i < 4; i++) begin
                m_digits[4*i +: 4] = sh_val[i];
                m_dp[i]            = sh_dp[i];
                m_blank[i]         = sh_blank[i];
                m_mask[i]          = 0;
            end
            m_fd = 1; m_valid = 1; since = 0;
        end else begin
            since++;
            if (since == TIMEOUT) begin
                m_valid = 0;
                for (int i = 0; i < 4; i++) m_mask[i] = 0;
            end
        end

        zeros = 0; idx = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) begin zeros++; idx = i; end
        legal = (a[7:4] == 4'hF) && (zeros == 1);
        if (!legal && a != 8'hFF) m_err = 1;

        if (legal && run == STABLE_CYC) begin
            found = 0; val = 0;
            for (int j = 0; j < n_pat; j++) if (pat[j] == s[6:0]) begin found = 1; val = j; end
            sh_blank[idx] = (!found && s[6:0] == 7'h7F);
            if (!found && !sh_blank[idx]) m_err = 1;
            sh_val[idx] = 4'(val);
            sh_dp[idx]  = ~s[7];
            m_mask[idx] = 1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    int cyc = 0, fd_cnt = 0, last_fd_cyc = 0, gap = -1;
    bit prev_valid = 0;

    initial begin
        forever begin
            @(posedge clk);
            model_edge(clear, an, sseg);
            #1;
            cyc++;
            check($sformatf("cycle %0d outputs", cyc),
                  {5'd0, digits, dp, blank, valid, frame_done, err},
                  {5'd0, m_digits, m_dp, m_blank, m_valid, m_fd, m_err});
            if (frame_done) begin
                fd_cnt++;
                last_fd_cyc = cyc;
            end
            if (prev_valid && !valid && !clear) gap = cyc - last_fd_cyc;
            prev_valid = valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic hold(input logic [7:0] a, input logic [7:0] s, input int n);
        repeat (n) begin
            @(negedge clk);
            an   = a;
            sseg = s;
        end
    endtask

    task automatic scan(input logic [7:0] s3, input logic [7:0] s2,
                        input logic [7:0] s1, input logic [7:0] s0, input int n);
        hold(8'hF7, s3, n);
        hold(8'hFB, s2, n);
        hold(8'hFD, s1, n);
        hold(8'hFE, s0, n);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        an    = 8'hFF;
        sseg  = 8'hFF;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset digits", 32'(digits), 32'h0);
        check("reset dp/blank", {24'd0, dp, blank}, 32'h0);
        check("reset valid/fd/err", {29'd0, valid, frame_done, err}, 32'h0);
        clear = 1'b0;
        hold(8'hFF, 8'hFF, 2);

        // "1234", dp off
        scan(8'hF9, 8'hA4, 8'hB0, 8'h99, 4);
        hold(8'hFF, 8'hFF, 3);
        check("1234 digits", 32'(digits), 32'h1234);
        check("1234 dp/blank", {24'd0, dp, blank}, 32'h0);
        check("1234 valid/err", {30'd0, valid, err}, 32'h2);
        check("1234 frame_done count", fd_cnt, 1);

        // "5678" with one-cycle anode glitches between digits
        hold(8'hF7, 8'h92, 3);
        hold(8'hFE, 8'h92, 1);
        hold(8'hFB, 8'h82, 3);
        hold(8'hFE, 8'h82, 1);
        hold(8'hFD, 8'hF8, 3);
        hold(8'hFE, 8'h80, 3);
        hold(8'hFF, 8'hFF, 3);
        check("glitch digits", 32'(digits), 32'h5678);
        check("glitch frame_done count", fd_cnt, 2);
        check("glitch err", 32'(err), 32'h0);

        // Illegal anode, err must stick through a good frame
        hold(8'hFC, 8'hF9, 3);
        hold(8'hFF, 8'hFF, 1);
        check("illegal anode err", 32'(err), 32'h1);
        scan(8'hF9, 8'hA4, 8'hB0, 8'h99, 4);
        hold(8'hFF, 8'hFF, 3);
        check("sticky err", 32'(err), 32'h1);
        check("post-err digits", 32'(digits), 32'h1234);

        do_clear();
        check("clear err", 32'(err), 32'h0);
        check("clear digits", 32'(digits), 32'h0);
        check("clear valid", 32'(valid), 32'h0);

        // Blank digit 3, "0." on digit 0
        scan(8'hFF, 8'hA4, 8'hB0, 8'h40, 4);
        hold(8'hFF, 8'hFF, 3);
        check("blank digits", 32'(digits), 32'h0230);
        check("blank mask", 32'(blank), 32'h8);
        check("dp mask", 32'(dp), 32'h1);
        check("blank frame_done count", fd_cnt, 4);

        // Timeout
        hold(8'hFF, 8'hFF, 60);
        check("timeout valid", 32'(valid), 32'h0);
        check("timeout gap", gap, TIMEOUT);
        check("timeout digits hold", {16'd0, digits}, 32'h0230);
        scan(8'hF9, 8'hA4, 8'hB0, 8'h99, 4);
        hold(8'hFF, 8'hFF, 3);
        check("recover valid", 32'(valid), 32'h1);
        check("recover digits", 32'(digits), 32'h1234);
        check("recover frame_done count", fd_cnt, 5);

        // Hex glyph A on digit 2
        scan(8'hF9, 8'h88, 8'hB0, 8'h99, 4);
        hold(8'hFF, 8'hFF, 3);
`ifdef SSEG_DEC_HEX_EN
        check("hex digits", 32'(digits), 32'h1A34);
        check("hex err", 32'(err), 32'h0);
`else
        check("hex digits", 32'(digits), 32'h1034);
        check("hex err", 32'(err), 32'h1);
`endif

        // clear mid-frame discards the partial mask
        hold(8'hF7, 8'hF9, 4);
        hold(8'hFB, 8'hA4, 4);
        do_clear();
        check("midclear digits", 32'(digits), 32'h0);
        check("midclear flags", {29'd0, valid, frame_done, err}, 32'h0);
        hold(8'hFD, 8'hF8, 4);
        hold(8'hFE, 8'h80, 4);
        hold(8'hFF, 8'hFF, 2);
        check("midclear no early publish", fd_cnt, 6);
        hold(8'hF7, 8'h92, 4);
        hold(8'hFB, 8'h82, 4);
        hold(8'hFF, 8'hFF, 3);
        check("midclear new digits", 32'(digits), 32'h5678);
        check("midclear frame_done count", fd_cnt, 7);
        check("midclear valid", 32'(valid), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
